// File: rtl/banco_pkg.sv
// Shared types and default sizing for the banco register file.
package banco_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } bancoState_t;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

endpackage

// File: rtl/banco_clear_ctrl.sv
// Clear-sweep controller: walks every entry once after reset or a clear request,
// then reports the bank as ready.
module banco_clear_ctrl
    import banco_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    // One extra bit keeps the terminal compare from wrapping back to zero.
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W + 1){1'b0}};

    bancoState_t       state;
    bancoState_t       stateNext;
    logic [ADDR_W:0]   clrPtr;
    logic [ADDR_W:0]   clrPtrNext;
    logic              readyR;

    // State, pointer and ready registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_CLEAR;
            clrPtr <= PTR_ZERO;
            readyR <= 1'b0;
        end else begin
            state  <= stateNext;
            clrPtr <= clrPtrNext;
            readyR <= (stateNext == ST_READY);
        end
    end

    // Sweep sequencing; clear requests only count once the bank is ready.
    always_comb begin
        stateNext  = state;
        clrPtrNext = clrPtr;
        case (state)
            ST_CLEAR: begin
                if (clrPtr == LAST_PTR) begin
                    stateNext  = ST_READY;
                    clrPtrNext = PTR_ZERO;
                end else begin
                    stateNext  = ST_CLEAR;
                    clrPtrNext = clrPtr + PTR_ONE;
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    stateNext  = ST_CLEAR;
                    clrPtrNext = PTR_ZERO;
                end else begin
                    stateNext  = ST_READY;
                    clrPtrNext = clrPtr;
                end
            end
            default: begin
                stateNext  = ST_CLEAR;
                clrPtrNext = PTR_ZERO;
            end
        endcase
    end

    assign ready    = readyR;
    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = clrPtr[ADDR_W-1:0];

endmodule

// File: rtl/banco_r_gen.sv
// Parametrised register file: two combinational read ports, one write port, sweep clear.
// Optional same-cycle write-to-read bypass when BANCO_BYPASS_EN is defined.
module banco_r_gen
    import banco_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr_r1,
    input  logic [ADDR_W-1:0] addr_r2,
    output logic [DATA_W-1:0] rx,
    output logic [DATA_W-1:0] ry,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clrWe;
    logic [ADDR_W-1:0] clrAddr;
    logic              userWe;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;
    logic              hitX;
    logic              hitY;

    function automatic logic isZeroAddr(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == ADDR_ZERO);
    endfunction

    banco_clear_ctrl #(.ADDR_W(ADDR_W)) u_clear_ctrl (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .ready    (ready),
        .clr_we   (clrWe),
        .clr_addr (clrAddr)
    );

    // A clear request in the same cycle beats the write.
    assign userWe = ready && w_en && !clr_req && !isZeroAddr(addr_w);

`ifdef BANCO_BYPASS_EN
    assign hitX = userWe && (addr_w == addr_r1);
    assign hitY = userWe && (addr_w == addr_r2);
`else
    assign hitX = 1'b0;
    assign hitY = 1'b0;
`endif

    // Write-port mux: sweep has priority over user writes.
    always_comb begin
        memWe   = 1'b0;
        memAddr = addr_w;
        memData = data_in;
        if (clrWe) begin
            memWe   = 1'b1;
            memAddr = clrAddr;
            memData = DATA_ZERO;
        end else if (userWe) begin
            memWe   = 1'b1;
        end else begin
            memWe   = 1'b0;
        end
    end

    // Storage array; contents are only ever cleared by the sweep.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memAddr] <= memData;
        end
    end

    // Read muxes, forced to zero while the sweep runs.
    always_comb begin
        rx = DATA_ZERO;
        ry = DATA_ZERO;
        if (!ready) begin
            rx = DATA_ZERO;
            ry = DATA_ZERO;
        end else begin
            if (isZeroAddr(addr_r1)) begin
                rx = DATA_ZERO;
            end else if (hitX) begin
                rx = data_in;
            end else begin
                rx = mem[addr_r1];
            end
            if (isZeroAddr(addr_r2)) begin
                ry = DATA_ZERO;
            end else if (hitY) begin
                ry = data_in;
            end else begin
                ry = mem[addr_r2];
            end
        end
    end

endmodule

// File: tb/tb_banco_r_gen.sv
// Randomised bench for banco_r_gen: one instance with ZERO_REG=0, one with ZERO_REG=1,
// both compared every cycle against a behavioural model of the bank.
module tb_banco_r_gen;

    logic       clk;
    logic       reset;
    logic       clrReq;
    logic       wEn;
    logic [2:0] addrW;
    logic [7:0] dataIn;
    logic [2:0] addrR1;
    logic [2:0] addrR2;
    logic [7:0] rxA, ryA, rxZ, ryZ;
    logic       readyA, readyZ;

    int nChecks = 0;
    int nErrors = 0;

`ifdef BANCO_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    // Model: contents per instance and number of sweep cycles still to go.
    logic [7:0] memA [8];
    logic [7:0] memZ [8];
    int         clearLeft;

    banco_r_gen #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dutA (
        .clk(clk), .reset(reset), .clr_req(clrReq), .w_en(wEn), .addr_w(addrW),
        .data_in(dataIn), .addr_r1(addrR1), .addr_r2(addrR2),
        .rx(rxA), .ry(ryA), .ready(readyA)
    );

    banco_r_gen #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dutZ (
        .clk(clk), .reset(reset), .clr_req(clrReq), .w_en(wEn), .addr_w(addrW),
        .data_in(dataIn), .addr_r1(addrR1), .addr_r2(addrR2),
        .rx(rxZ), .ry(ryZ), .ready(readyZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic startSweep();
        clearLeft = 8;
        for (int i = 0; i < 8; i++) begin
            memA[i] = 8'h00;
            memZ[i] = 8'h00;
        end
    endtask

    function automatic logic [7:0] expRead(input bit z, input logic [2:0] a);
        if (clearLeft != 0) return 8'h00;
        if (z && a == 3'd0) return 8'h00;
        if (BYPASS_EN && wEn && !clrReq && addrW == a && !(z && addrW == 3'd0)) return dataIn;
        return z ? memZ[a] : memA[a];
    endfunction

    task automatic drive(input logic r, input logic cr, input logic we, input logic [2:0] aw,
                         input logic [7:0] d, input logic [2:0] a1, input logic [2:0] a2);
        reset  = r;
        clrReq = cr;
        wEn    = we;
        addrW  = aw;
        dataIn = d;
        addrR1 = a1;
        addrR2 = a2;
        if (!r) startSweep();
    endtask

    task automatic modelEdge();
        if (!reset) begin
            startSweep();
        end else if (clearLeft > 0) begin
            clearLeft--;
        end else if (clrReq) begin
            startSweep();
        end else if (wEn) begin
            memA[addrW] = dataIn;
            if (addrW != 3'd0) memZ[addrW] = dataIn;
        end
    endtask

    // Check outputs mid-low-phase, advance one clock, update model, return at negedge.
    task automatic step();
        #1;
        checkEq("A.ready", {31'd0, readyA}, {31'd0, clearLeft == 0});
        checkEq("Z.ready", {31'd0, readyZ}, {31'd0, clearLeft == 0});
        checkEq("A.rx", {24'd0, rxA}, {24'd0, expRead(1'b0, addrR1)});
        checkEq("A.ry", {24'd0, ryA}, {24'd0, expRead(1'b0, addrR2)});
        checkEq("Z.rx", {24'd0, rxZ}, {24'd0, expRead(1'b1, addrR1)});
        checkEq("Z.ry", {24'd0, ryZ}, {24'd0, expRead(1'b1, addrR2)});
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'($urandom_range(7)), 3'($urandom_range(7)));
            step();
        end
    endtask

    initial begin
        logic [2:0] a1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);

        // Reset held 3 cycles, then sweep of 8 cycles, then all entries read zero.
        for (int i = 0; i < 3; i++) step();
        idle(10);
        for (int a = 0; a < 8; a++) begin
            drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'(a), 3'(7 - a));
            step();
        end

        // Two writes, then read them back on both ports.
        drive(1'b1, 1'b0, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd7); step();
        drive(1'b1, 1'b0, 1'b1, 3'd7, 8'h3C, 3'd3, 3'd7); step();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd7); step();

        // Clear request wins over a simultaneous write.
        drive(1'b1, 1'b0, 1'b1, 3'd5, 8'h11, 3'd5, 3'd5); step();
        drive(1'b1, 1'b1, 1'b1, 3'd5, 8'hFF, 3'd5, 3'd3); step();
        idle(9);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd3); step();

        // Same-cycle write and read of one address.
        drive(1'b1, 1'b0, 1'b1, 3'd2, 8'h33, 3'd1, 3'd1); step();
        drive(1'b1, 1'b0, 1'b1, 3'd2, 8'h5A, 3'd2, 3'd2); step();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd2); step();

        // Write to entry 0: ignored on the ZERO_REG instance.
        drive(1'b1, 1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd0); step();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd2); step();

        // Reset mid-sweep restarts the sweep.
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0); step();
        idle(4);
        drive(1'b0, 1'b0, 1'b1, 3'd4, 8'h77, 3'd4, 3'd4); step();
        idle(10);

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 800; i++) begin
            a1 = 3'($urandom_range(7));
            drive(($urandom_range(149) != 0),
                  ($urandom_range(39) == 0),
                  ($urandom_range(1) == 1),
                  3'($urandom_range(7)),
                  8'($urandom),
                  a1,
                  ($urandom_range(3) == 0) ? a1 : 3'($urandom_range(7)));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
